// File: rtl/exec_pkg.sv
// Shared opcode encodings and FSM state type for the multi-cycle execute unit.
package exec_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB = 4'd1;
  localparam logic [OP_W-1:0] OP_AND = 4'd2;
  localparam logic [OP_W-1:0] OP_OR  = 4'd3;
  localparam logic [OP_W-1:0] OP_XOR = 4'd4;
  localparam logic [OP_W-1:0] OP_SLL = 4'd5;
  localparam logic [OP_W-1:0] OP_SRL = 4'd6;
  localparam logic [OP_W-1:0] OP_SRA = 4'd7;
  localparam logic [OP_W-1:0] OP_MUL = 4'd8;
  localparam logic [OP_W-1:0] OP_MOV = 4'd9;
  localparam logic [OP_W-1:0] OP_BRZ = 4'd10;
  localparam logic [OP_W-1:0] OP_BRN = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/exec_mul_iter.sv
// Iterative shift-add multiplier retiring MUL_BITS of operand B per falling edge.
module exec_mul_iter
  import exec_pkg::*;
#(
  parameter int unsigned REG_WIDTH = 16,
  parameter int unsigned MUL_BITS  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 step,
  input  logic [REG_WIDTH-1:0] a,
  input  logic [REG_WIDTH-1:0] b,
  output logic                 done_c,
  output logic [REG_WIDTH-1:0] sum_c,
  output logic [REG_WIDTH-1:0] acc
);

  localparam int unsigned STEPS = REG_WIDTH / MUL_BITS;
  localparam int unsigned CNT_W = $clog2(STEPS + 1);

  logic [REG_WIDTH-1:0] a_sh;
  logic [REG_WIDTH-1:0] b_sh;
  logic [CNT_W-1:0]     cnt;
  logic [REG_WIDTH-1:0] partial_c;

  // Only the low REG_WIDTH bits of the product are ever needed.
  assign partial_c = a_sh * REG_WIDTH'(b_sh[MUL_BITS-1:0]);
  assign sum_c     = acc + partial_c;
  assign done_c    = (cnt == CNT_W'(1));

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      acc  <= '0;
      cnt  <= '0;
    end else if (start) begin
      a_sh <= a;
      b_sh <= b;
      acc  <= '0;
      cnt  <= CNT_W'(STEPS);
    end else if (step && (cnt != '0)) begin
      acc  <= sum_c;
      a_sh <= a_sh << MUL_BITS;
      b_sh <= b_sh >> MUL_BITS;
      cnt  <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/exec_unit_mc.sv
// Execute stage: single-cycle ALU/branch ops, iterative MUL, valid/ready with back-pressure.
module exec_unit_mc
  import exec_pkg::*;
#(
  parameter int unsigned REG_WIDTH    = 16,
  parameter int unsigned PC_WIDTH     = 16,
  parameter int unsigned REGIDX_WIDTH = 4,
  parameter int unsigned MUL_BITS     = 2
) (
  input  logic                    I_CLOCK,
  input  logic                    I_RESET_N,
  input  logic                    I_LOCK,
  input  logic [PC_WIDTH-1:0]     I_PC,
  input  logic [OP_W-1:0]         I_Opcode,
  input  logic [REG_WIDTH-1:0]    I_Src1Value,
  input  logic [REG_WIDTH-1:0]    I_Src2Value,
  input  logic [REG_WIDTH-1:0]    I_Imm,
  input  logic                    I_UseImm,
  input  logic [REGIDX_WIDTH-1:0] I_DestRegIdx,
  input  logic                    I_StallIn,
  output logic                    O_Ready,
  output logic                    O_LOCK,
  output logic [REG_WIDTH-1:0]    O_ALUOut,
  output logic [OP_W-1:0]         O_Opcode,
  output logic [REGIDX_WIDTH-1:0] O_DestRegIdx,
  output logic                    O_BrTaken,
  output logic [PC_WIDTH-1:0]     O_BrTarget,
  output logic                    O_Overflow
);

  localparam int unsigned SH_W = $clog2(REG_WIDTH);
  localparam int unsigned MSB  = REG_WIDTH - 1;

  state_t                  state, state_d;
  logic                    hold_c, accept_c, mul_start_c, mul_done_c;
  logic [REG_WIDTH-1:0]    op_b_c, alu_c, mul_sum_c, mul_acc;
  logic [SH_W-1:0]         sh_c;
  logic                    br_c, ovf_c;
  logic [PC_WIDTH-1:0]     tgt_c;
  logic [REGIDX_WIDTH-1:0] mul_dest;
  logic [PC_WIDTH-1:0]     mul_tgt;

  logic                    lock_d, br_d, ovf_d;
  logic [REG_WIDTH-1:0]    alu_d;
  logic [OP_W-1:0]         opcode_d;
  logic [REGIDX_WIDTH-1:0] dest_d;
  logic [PC_WIDTH-1:0]     tgt_d;

  assign hold_c      = O_LOCK && I_StallIn;
  assign O_Ready     = (state == ST_IDLE) && !hold_c;
  assign accept_c    = I_LOCK && O_Ready;
  assign mul_start_c = accept_c && (I_Opcode == OP_MUL);
  assign op_b_c      = I_UseImm ? I_Imm : I_Src2Value;
  assign sh_c        = op_b_c[SH_W-1:0];
  assign tgt_c       = I_PC + I_Imm[PC_WIDTH-1:0];

  exec_mul_iter #(
    .REG_WIDTH (REG_WIDTH),
    .MUL_BITS  (MUL_BITS)
  ) u_mul (
    .clk    (I_CLOCK),
    .rst_n  (I_RESET_N),
    .start  (mul_start_c),
    .step   (state == ST_MUL),
    .a      (I_Src1Value),
    .b      (op_b_c),
    .done_c (mul_done_c),
    .sum_c  (mul_sum_c),
    .acc    (mul_acc)
  );

  // Single-cycle ALU and branch resolution
  always_comb begin
    alu_c = '0;
    br_c  = 1'b0;
    ovf_c = 1'b0;
    case (I_Opcode)
      OP_ADD: begin
        alu_c = I_Src1Value + op_b_c;
        ovf_c = (I_Src1Value[MSB] == op_b_c[MSB]) && (alu_c[MSB] != I_Src1Value[MSB]);
      end
      OP_SUB: begin
        alu_c = I_Src1Value - op_b_c;
        ovf_c = (I_Src1Value[MSB] != op_b_c[MSB]) && (alu_c[MSB] != I_Src1Value[MSB]);
      end
      OP_AND: alu_c = I_Src1Value & op_b_c;
      OP_OR:  alu_c = I_Src1Value | op_b_c;
      OP_XOR: alu_c = I_Src1Value ^ op_b_c;
      OP_SLL: alu_c = I_Src1Value << sh_c;
      OP_SRL: alu_c = I_Src1Value >> sh_c;
      OP_SRA: alu_c = REG_WIDTH'($signed(I_Src1Value) >>> sh_c);
      OP_MOV: alu_c = op_b_c;
      OP_BRZ: br_c  = (I_Src1Value == '0);
      OP_BRN: br_c  = I_Src1Value[MSB];
      default: ;
    endcase
  end

  // Next state and next output values; outputs hold unless a result completes
  always_comb begin
    state_d  = state;
    lock_d   = hold_c;
    alu_d    = O_ALUOut;
    opcode_d = O_Opcode;
    dest_d   = O_DestRegIdx;
    br_d     = O_BrTaken;
    tgt_d    = O_BrTarget;
    ovf_d    = O_Overflow;
    case (state)
      ST_IDLE: begin
        if (accept_c) begin
          if (I_Opcode == OP_MUL) begin
            state_d = ST_MUL;
          end else begin
            lock_d   = 1'b1;
            alu_d    = alu_c;
            opcode_d = I_Opcode;
            dest_d   = I_DestRegIdx;
            br_d     = br_c;
            tgt_d    = tgt_c;
            ovf_d    = ovf_c;
          end
        end
      end
      ST_MUL: begin
        if (mul_done_c) begin
          if (hold_c) begin
            state_d = ST_DONE;
          end else begin
            state_d  = ST_IDLE;
            lock_d   = 1'b1;
            alu_d    = mul_sum_c;
            opcode_d = OP_MUL;
            dest_d   = mul_dest;
            br_d     = 1'b0;
            tgt_d    = mul_tgt;
            ovf_d    = 1'b0;
          end
        end
      end
      ST_DONE: begin
        if (!hold_c) begin
          state_d  = ST_IDLE;
          lock_d   = 1'b1;
          alu_d    = mul_acc;
          opcode_d = OP_MUL;
          dest_d   = mul_dest;
          br_d     = 1'b0;
          tgt_d    = mul_tgt;
          ovf_d    = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      state        <= ST_IDLE;
      O_LOCK       <= 1'b0;
      O_ALUOut     <= '0;
      O_Opcode     <= '0;
      O_DestRegIdx <= '0;
      O_BrTaken    <= 1'b0;
      O_BrTarget   <= '0;
      O_Overflow   <= 1'b0;
    end else begin
      state        <= state_d;
      O_LOCK       <= lock_d;
      O_ALUOut     <= alu_d;
      O_Opcode     <= opcode_d;
      O_DestRegIdx <= dest_d;
      O_BrTaken    <= br_d;
      O_BrTarget   <= tgt_d;
      O_Overflow   <= ovf_d;
    end
  end

  // Passthrough fields of an in-flight multiply
  always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      mul_dest <= '0;
      mul_tgt  <= '0;
    end else if (mul_start_c) begin
      mul_dest <= I_DestRegIdx;
      mul_tgt  <= tgt_c;
    end
  end

endmodule

// File: tb/tb_exec_unit_mc.sv
// Scoreboard bench for exec_unit_mc: directed cases plus randomized traffic with back-pressure.
module tb_exec_unit_mc;
  import exec_pkg::*;

  logic        I_CLOCK, I_RESET_N, I_LOCK, I_UseImm, I_StallIn;
  logic [15:0] I_PC, I_Src1Value, I_Src2Value, I_Imm;
  logic [3:0]  I_Opcode, I_DestRegIdx;
  logic        O_Ready, O_LOCK, O_BrTaken, O_Overflow;
  logic [15:0] O_ALUOut, O_BrTarget;
  logic [3:0]  O_Opcode, O_DestRegIdx;

  typedef struct {
    logic [15:0] alu;
    logic [3:0]  op;
    logic [3:0]  dst;
    logic        br;
    logic [15:0] tgt;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   stall_pct = 0;
  int   last_wait = 0;

  exec_unit_mc dut (
    .I_CLOCK(I_CLOCK), .I_RESET_N(I_RESET_N), .I_LOCK(I_LOCK), .I_PC(I_PC),
    .I_Opcode(I_Opcode), .I_Src1Value(I_Src1Value), .I_Src2Value(I_Src2Value),
    .I_Imm(I_Imm), .I_UseImm(I_UseImm), .I_DestRegIdx(I_DestRegIdx),
    .I_StallIn(I_StallIn), .O_Ready(O_Ready), .O_LOCK(O_LOCK), .O_ALUOut(O_ALUOut),
    .O_Opcode(O_Opcode), .O_DestRegIdx(O_DestRegIdx), .O_BrTaken(O_BrTaken),
    .O_BrTarget(O_BrTarget), .O_Overflow(O_Overflow)
  );

  initial I_CLOCK = 1'b0;
  always #5 I_CLOCK = ~I_CLOCK;

  // Reference model: plain integer arithmetic on 16-bit two's-complement values
  function automatic exp_t model(input int op, input int a, input int b2, input int imm,
                                 input int ui, input int dst, input int pc);
    exp_t r;
    int b, sa, sb, s, sh;
    longint p;
    b  = ui ? imm : b2;
    sa = (a >= 32768) ? a - 65536 : a;
    sb = (b >= 32768) ? b - 65536 : b;
    sh = b % 16;
    r.alu = 16'h0; r.br = 1'b0; r.ovf = 1'b0;
    r.op = 4'(op); r.dst = 4'(dst); r.tgt = 16'((pc + imm) % 65536);
    case (op)
      0: begin s = sa + sb; r.alu = 16'((a + b) % 65536); r.ovf = (s > 32767) || (s < -32768); end
      1: begin s = sa - sb; r.alu = 16'((a - b + 65536) % 65536); r.ovf = (s > 32767) || (s < -32768); end
      2: r.alu = 16'(a & b);
      3: r.alu = 16'(a | b);
      4: r.alu = 16'(a ^ b);
      5: begin p = longint'(a) * (longint'(1) << sh); r.alu = 16'(p % 65536); end
      6: r.alu = 16'(a / (1 << sh));
      7: r.alu = 16'((sa >>> sh) & 32'hFFFF);
      8: begin p = longint'(a) * longint'(b); r.alu = 16'(p % 65536); end
      9: r.alu = 16'(b);
      10: r.br = (a == 0);
      11: r.br = (a >= 32768);
      default: ;
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge I_CLOCK);
    #1;
    if (stall_pct > 0) I_StallIn = ($urandom_range(99) < stall_pct);
  endtask

  // Present one instruction, wait (bounded) for acceptance, push its expected result
  task automatic issue(input int op, input int a, input int b, input int imm, input int ui,
                       input int dst, input int pc);
    int guard;
    I_LOCK = 1'b1; I_Opcode = 4'(op); I_Src1Value = 16'(a); I_Src2Value = 16'(b);
    I_Imm = 16'(imm); I_UseImm = ui[0]; I_DestRegIdx = 4'(dst); I_PC = 16'(pc);
    #1;
    guard = 0;
    while (!O_Ready && guard < 200) begin
      tick();
      #1;
      guard++;
    end
    last_wait = guard;
    checks++;
    if (!O_Ready) begin
      errors++;
      $display("FAIL accept_timeout ready=%0b required=1", O_Ready);
    end else begin
      exp_q.push_back(model(op, a, b, imm, ui, dst, pc));
    end
    tick();
    I_LOCK = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    stall_pct = 0;
    I_StallIn = 1'b0;
    while (exp_q.size() != 0 && guard < 500) begin
      tick();
      guard++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_lock"}, O_LOCK, 0);
    chk({tag, "_aluout"}, O_ALUOut, 0);
    chk({tag, "_opcode"}, O_Opcode, 0);
    chk({tag, "_brtaken"}, O_BrTaken, 0);
    chk({tag, "_brtarget"}, O_BrTarget, 0);
    chk({tag, "_ovf"}, O_Overflow, 0);
  endtask

  // Monitor: a result transfers when O_LOCK is high and downstream is not stalling
  initial begin
    exp_t e;
    forever begin
      @(posedge I_CLOCK);
      #3;
      if (I_RESET_N && O_LOCK) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output alu=0x%0h op=%0d with no pending expectation", O_ALUOut, O_Opcode);
        end else begin
          e = exp_q[0];
          if (O_ALUOut !== e.alu || O_Opcode !== e.op || O_DestRegIdx !== e.dst ||
              O_BrTaken !== e.br || O_BrTarget !== e.tgt || O_Overflow !== e.ovf) begin
            errors++;
            $display("FAIL result actual alu=0x%0h op=%0d dst=%0d br=%0b tgt=0x%0h ovf=%0b required alu=0x%0h op=%0d dst=%0d br=%0b tgt=0x%0h ovf=%0b",
                     O_ALUOut, O_Opcode, O_DestRegIdx, O_BrTaken, O_BrTarget, O_Overflow,
                     e.alu, e.op, e.dst, e.br, e.tgt, e.ovf);
          end
          if (I_StallIn) begin
            checks++;
            if (O_Ready !== 1'b0) begin
              errors++;
              $display("FAIL ready_during_hold actual=%0b required=0", O_Ready);
            end
          end else begin
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    int n;
    I_RESET_N = 1'b0; I_StallIn = 1'b0;
    I_LOCK = 1'b1; I_Opcode = OP_ADD; I_Src1Value = 16'h7FFF; I_Src2Value = 16'h0001;
    I_Imm = 16'h0; I_UseImm = 1'b0; I_DestRegIdx = 4'd3; I_PC = 16'h0100;

    // Reset held with a valid instruction present
    tick(); tick();
    #1;
    chk_zero_outputs("reset");
    chk("reset_ready", O_Ready, 1);
    I_RESET_N = 1'b1;
    issue(0, 16'h7FFF, 16'h0001, 0, 0, 3, 16'h0100);

    // Back-to-back single-cycle ops
    issue(4, 16'h00FF, 16'h0F0F, 0, 0, 1, 16'h0010);
    chk("b2b_xor_wait", last_wait, 0);
    issue(7, 16'h8000, 3, 0, 0, 2, 16'h0012);
    chk("b2b_sra_wait", last_wait, 0);
    issue(9, 0, 16'hAAAA, 16'h1234, 1, 4, 16'h0014);
    chk("b2b_mov_wait", last_wait, 0);
    drain();

    // Multi-cycle multiply latency and wrap
    issue(8, 16'h0013, 16'h0021, 0, 0, 5, 16'h0020);
    n = 0;
    #1;
    while (!O_Ready && n < 50) begin
      n++;
      tick();
      #1;
    end
    chk("mul_ready_low_edges", n, 8);
    issue(8, 16'hFFFF, 16'hFFFF, 0, 0, 6, 16'h0022);
    drain();

    // Stall holds a SUB result; next op is accepted on the release edge
    issue(1, 5, 7, 0, 0, 7, 16'h0030);
    I_StallIn = 1'b1;
    tick(); tick();
    I_StallIn = 1'b0;
    issue(0, 16'h8000, 16'h8000, 0, 0, 8, 16'h0032);
    chk("stall_release_wait", last_wait, 0);
    drain();

    // Branches, including target wrap
    issue(10, 0, 0, 16'h0020, 0, 9, 16'hFFF0);
    issue(11, 16'h0001, 0, 16'h0004, 0, 9, 16'h0040);
    issue(11, 16'h8001, 0, 16'h0004, 0, 9, 16'h0040);
    issue(13, 16'h1234, 16'h5678, 16'h0002, 1, 10, 16'h0050);
    drain();

    // Reset during a multiply discards it
    issue(8, 16'h0123, 16'h0045, 0, 0, 11, 16'h0060);
    tick(); tick(); tick();
    I_RESET_N = 1'b0;
    exp_q.delete();
    #1;
    chk_zero_outputs("midmul_reset");
    chk("midmul_reset_ready", O_Ready, 1);
    tick();
    I_RESET_N = 1'b1;
    issue(0, 2, 3, 0, 0, 12, 16'h0070);
    for (int i = 0; i < 15; i++) tick();
    chk("post_reset_pending", exp_q.size(), 0);

    // Randomized traffic with random back-pressure
    stall_pct = 25;
    for (int i = 0; i < 300; i++) begin
      int op, a, b;
      op = $urandom_range(15);
      a  = ($urandom_range(4) == 0) ? 0 : int'($urandom_range(65535));
      b  = int'($urandom_range(65535));
      issue(op, a, b, int'($urandom_range(65535)), int'($urandom_range(1)),
            int'($urandom_range(15)), int'($urandom_range(65535)));
      if ($urandom_range(3) == 0) tick();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
